shared_task_arbiter: RTL and testbench

Round-robin controller that shares one start/done-handshake worker (an `exp_with_en`-style unit) between N requesters. It sequences the worker by driving its `start_sig` and routing its `done_sig` back to the owner. It sits between the requesting control FSMs and the single worker instance. An optional watchdog aborts transactions the worker never completes.

---
 rtl/shared_task_arbiter.sv | 125 ++++++++++++
 tb/tb_shared_task_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_task_arbiter.sv
// Round-robin owner of one start/done worker shared by N requesters.
// Define SHARED_TASK_ARB_TIMEOUT_EN to add the RUN watchdog and err_out.
module shared_task_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_sig,
    output logic [N-1:0] grant,
    output logic [N-1:0] done_out,
    output logic [N-1:0] err_out,
    output logic         start_sig,
    input  logic         done_sig,
    output logic         busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] pick;
    logic          any_req;
    logic [N-1:0]  pick_onehot;
    logic          expire;

    // First asserted request after the last owner, wrapping modulo N.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any_req && req_sig[(int'(last) + i) % N]) begin
                any_req = 1'b1;
                pick    = IW'((int'(last) + i) % N);
            end
        end
    end

    always_comb begin
        pick_onehot       = '0;
        pick_onehot[pick] = 1'b1;
    end

`ifdef SHARED_TASK_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(TIMEOUT - 1));

    // Cleared while idle so every RUN starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            err_out <= '0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
            end
            if (state == RUN && !done_sig && expire) begin
                err_out <= grant;
            end else begin
                err_out <= '0;
            end
        end
    end
`else
    wire [31:0] unused_timeout = 32'(TIMEOUT);

    assign expire  = 1'b0;
    assign err_out = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IW'(N - 1);
            grant     <= '0;
            start_sig <= 1'b0;
            busy      <= 1'b0;
            done_out  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= RUN;
                        last      <= pick;
                        grant     <= pick_onehot;
                        start_sig <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    // done_sig beats a simultaneous watchdog expiry.
                    if (done_sig) begin
                        state     <= DONE;
                        start_sig <= 1'b0;
                        done_out  <= grant;
                    end else if (expire) begin
                        state     <= DONE;
                        start_sig <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    grant    <= '0;
                    busy     <= 1'b0;
                    done_out <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_task_arbiter.sv
// Directed bench for shared_task_arbiter with N=4, TIMEOUT=20.
// Watchdog steps run only when SHARED_TASK_ARB_TIMEOUT_EN is defined.
module tb_shared_task_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_sig;
    logic [3:0] grant;
    logic [3:0] done_out;
    logic [3:0] err_out;
    logic       start_sig;
    logic       done_sig;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    shared_task_arbiter #(.N(4), .TIMEOUT(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_sig   (req_sig),
        .grant     (grant),
        .done_out  (done_out),
        .err_out   (err_out),
        .start_sig (start_sig),
        .done_sig  (done_sig),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req_sig  = 4'b0000;
        done_sig = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
    endtask

    // Grant at the next edge, done_sig sampled lat edges after start rises.
    task automatic txn(input string tag, input logic [3:0] exp, input int lat);
        tick();
        check({tag, "_grant"}, 32'(grant), 32'(exp));
        check({tag, "_start"}, 32'(start_sig), 32'd1);
        repeat (lat - 1) tick();
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        check({tag, "_done"}, 32'(done_out), 32'(exp));
        check({tag, "_err"}, 32'(err_out), 32'd0);
        tick();
    endtask

    initial begin
        int bad;
        int hi;

        // Reset hold with every requester asserted
        rst_n    = 1'b0;
        done_sig = 1'b0;
        req_sig  = 4'b1111;
        bad      = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grant !== 4'b0000 || start_sig !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst_hold", 32'(bad), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_rel_grant", 32'(grant), 32'b0001);
        check("rst_rel_start", 32'(start_sig), 32'd1);
        check("rst_rel_busy", 32'(busy), 32'd1);

        // Single requester, worker responds 5 cycles after start
        do_reset();
        req_sig = 4'b0100;
        tick();
        check("single_grant", 32'(grant), 32'b0100);
        hi = start_sig ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (start_sig) hi++;
        end
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        if (start_sig) hi++;
        check("single_start_len", 32'(hi), 32'd6);
        check("single_done", 32'(done_out), 32'b0100);
        check("single_err", 32'(err_out), 32'd0);
        check("single_done_grant", 32'(grant), 32'b0100);
        req_sig = 4'b0000;
        tick();
        check("single_idle_pulse", 32'(done_out), 32'd0);
        check("single_idle_grant", 32'(grant), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);
        req_sig = 4'b0100;
        tick();
        check("single_regrant", 32'(grant), 32'b0100);
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        req_sig  = 4'b0000;
        tick();

        // Fairness with all four requesting
        do_reset();
        req_sig = 4'b1111;
        txn("rr0", 4'b0001, 3);
        txn("rr1", 4'b0010, 3);
        txn("rr2", 4'b0100, 3);
        txn("rr3", 4'b1000, 3);
        txn("rr4", 4'b0001, 3);

        // Two requesters alternate
        do_reset();
        req_sig = 4'b1001;
        txn("alt0", 4'b0001, 2);
        txn("alt1", 4'b1000, 2);
        txn("alt2", 4'b0001, 2);

        // Owner drops its request mid-RUN, non-owner toggles
        do_reset();
        req_sig = 4'b0001;
        tick();
        check("drop_grant", 32'(grant), 32'b0001);
        req_sig = 4'b0100;
        tick();
        req_sig = 4'b0000;
        tick();
        check("drop_grant_held", 32'(grant), 32'b0001);
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        check("drop_done", 32'(done_out), 32'b0001);
        tick();

        // done_sig on the edge the counter reaches TIMEOUT-1
        do_reset();
        req_sig = 4'b0010;
        tick();
        repeat (19) tick();
        check("coll_still_run", 32'(start_sig), 32'd1);
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        check("coll_done", 32'(done_out), 32'b0010);
        check("coll_err", 32'(err_out), 32'd0);
        req_sig = 4'b0000;
        tick();

`ifdef SHARED_TASK_ARB_TIMEOUT_EN
        // Worker never answers; requester 2 pending
        do_reset();
        req_sig = 4'b0110;
        tick();
        check("to_grant", 32'(grant), 32'b0010);
        hi = start_sig ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!start_sig) break;
            hi++;
        end
        check("to_start_len", 32'(hi), 32'd20);
        check("to_err", 32'(err_out), 32'b0010);
        check("to_done", 32'(done_out), 32'd0);
        check("to_err_grant", 32'(grant), 32'b0010);
        req_sig = 4'b0100;
        tick();
        check("to_err_clear", 32'(err_out), 32'd0);
        tick();
        check("to_next_grant", 32'(grant), 32'b0100);
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        req_sig  = 4'b0000;
        tick();
`else
        // Without the watchdog RUN waits indefinitely
        do_reset();
        req_sig = 4'b0010;
        tick();
        repeat (60) tick();
        check("nowd_start", 32'(start_sig), 32'd1);
        check("nowd_err", 32'(err_out), 32'd0);
        check("nowd_busy", 32'(busy), 32'd1);
        done_sig = 1'b1;
        tick();
        done_sig = 1'b0;
        check("nowd_done", 32'(done_out), 32'b0010);
        req_sig = 4'b0000;
        tick();
`endif

        // Reset mid-RUN restores requester 0 priority
        do_reset();
        req_sig = 4'b1111;
        txn("mr0", 4'b0001, 2);
        tick();
        check("mr_run_grant", 32'(grant), 32'b0010);
        tick();
        rst_n = 1'b0;
        tick();
        check("mr_start", 32'(start_sig), 32'd0);
        check("mr_grant", 32'(grant), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done_out), 32'd0);
        check("mr_err", 32'(err_out), 32'd0);
        rst_n = 1'b1;
        tick();
        check("mr_regrant", 32'(grant), 32'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
